bit_scan_iterator: RTL and testbench
====================================

Name: bit_scan_iterator

Overview:
Parametrised successor to the 4-bit lowest-set-bit position encoder. It accepts a WIDTH-bit vector over a valid/ready input handshake. It then emits the index of every set bit, lowest first, one per accepted output beat over a valid/ready output stream, and flags the final beat. It sits in front of per-bit service logic such as request/interrupt dispatch, and replaces purely combinational position encoding wherever all set bits must be visited.

Parameters:
WIDTH, 8, vector width in bits; minimum 2.
IDXW, $clog2(WIDTH), index width (derived localparam, not overridable).

Ports:
clk        in   1      clock; single clock domain
rst_n      in   1      reset, asynchronous, active-low
in_valid   in   1      input vector valid
in_ready   out  1      block can accept a vector
in_data    in   WIDTH  vector to scan
flush      in   1      synchronous abort of the current scan
out_valid  out  1      index beat valid
out_ready  in   1      consumer accepts beat
out_idx    out  IDXW   position of lowest remaining set bit
out_last   out  1      final beat for the current vector
out_none   out  1      vector was all-zero (sole beat)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state IDLE, remaining-vector register 0, zero-flag 0. This gives out_valid=0, out_idx=0, out_last=0, out_none=0, in_ready=1.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: in_ready=0, out_valid=1.
- Accept: in_valid&&in_ready in IDLE.
  - in_data is registered into rem; zero-flag is set to (in_data==0).
  - Next state is SCAN; out_valid rises the cycle after accept (1-cycle latency).
- Outputs in SCAN, combinational from registers:
  - out_idx = lowest set bit of rem.
  - out_last = (rem has exactly one bit set) || zero-flag.
  - out_none = zero-flag.
- All-zero vector: exactly one beat with out_idx=0, out_none=1, out_last=1. This matches the legacy encoder mapping 0 to 0.
- Beat transfer: on out_valid&&out_ready, clear bit out_idx in rem.
  - If out_last, go to IDLE.
  - in_ready returns to 1 on the next cycle; no same-cycle reload, so there is at least one IDLE cycle between vectors.
- Backpressure: while out_valid&&!out_ready, out_idx/out_last/out_none are held stable, and rem and state are unchanged.
- flush=1:
  - In any state: next cycle is IDLE with rem=0 and zero-flag=0.
  - flush takes priority over a simultaneous beat transfer.
  - flush in IDLE also blocks acceptance that cycle; in_ready is forced 0 while flush=1.
- Reset asserted mid-scan: outputs go to reset values immediately (asynchronously). No partial beat may appear after deassertion.
- Beat count per vector = popcount(in_data), or 1 if the vector is zero. The maximum is WIDTH beats.
- No arithmetic beyond the bit clear (rem & ~onehot(out_idx)); no width growth.
- in_data is ignored outside the accept cycle.

Decomposition:
- Package bit_scan_pkg:
  - function clog2 for IDXW.
  - function onehot(idx, WIDTH).
  - state enum {IDLE, SCAN}.
- One combinational sub-module, lsb_priority_enc #(WIDTH):
  - Inputs: vec.
  - Outputs: idx (lowest set bit; 0 for a zero vector), single (exactly one bit set), zero.
- The top block contains the FSM, rem/zero-flag registers, and handshake logic.

Test Plan:
- Reset: rst_n=0 asynchronously during SCAN of 8'hFF -> same cycle out_valid=0, in_ready=1; after release, first accepted vector 8'h02 -> single beat idx=1, last=1.
- Multi-bit scan: in_data=8'b1010_0100, out_ready=1 -> beats idx=2,5,7 on consecutive cycles with last only on idx=7, none=0. in_ready=1 exactly one cycle after the idx=7 beat.
- Zero vector: in_data=8'h00 -> exactly one beat with idx=0, none=1, last=1, then IDLE.
- Backpressure: in_data=8'h81, out_ready=0 for 3 cycles -> idx=0, last=0 held stable all 3 cycles. Then out_ready=1 -> idx=0, then idx=7 with last=1.
- Flush: in_data=8'hFF, accept beats idx=0 and 1, then flush=1 together with out_ready=1 -> next cycle out_valid=0 and in_ready=1. Beat idx=2 is never counted as transferred.
- Width generalisation: WIDTH=16, in_data=16'h8001 -> idx=0 then idx=15 with last=1. in_valid held high on the final beat cycle is not accepted until the following IDLE cycle.

Source files
------------

// File: rtl/bit_scan_iterator_pkg.sv
// bit_scan_pkg: shared types and helpers for the bit scan iterator.
//   clog2  : ceiling log2, used to size index ports
//   onehot : one-hot mask of a bit index, up to MAXW bits wide
//   state_t: scan FSM states
package bit_scan_pkg;
   localparam int MAXW = 256;
   typedef enum logic {IDLE, SCAN} state_t;
   function automatic int clog2(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++);
      return r;
   endfunction
   // Callers truncate the result to their own width; w guards out-of-range indices.
   function automatic logic [MAXW-1:0] onehot(input int idx, input int w);
      return (idx < w) ? (MAXW'(1) << idx) : '0;
   endfunction
endpackage

// File: rtl/bit_scan_iterator_if.sv
// bit_scan_iterator_if: vector input stream, index output stream and flush.
//   in_valid/in_ready/in_data       : vector handshake (master -> slave)
//   flush                           : synchronous abort (master -> slave)
//   out_valid/out_ready             : index beat handshake (slave -> master)
//   out_idx/out_last/out_none       : beat payload (slave -> master)
interface bit_scan_iterator_if #(parameter int WIDTH = 8);
   localparam int IDXW = bit_scan_pkg::clog2(WIDTH);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [IDXW-1:0]  out_idx;
   logic             out_last;
   logic             out_none;
   modport slave (input in_valid, in_data, flush, out_ready,
                  output in_ready, out_valid, out_idx, out_last, out_none);
   modport master (output in_valid, in_data, flush, out_ready,
                   input in_ready, out_valid, out_idx, out_last, out_none);
endinterface

// File: rtl/bit_scan_iterator_enc.sv
// lsb_priority_enc: combinational lowest-set-bit encoder.
//   vec    : input vector
//   idx    : position of lowest set bit, 0 for a zero vector
//   single : exactly one bit set
//   zero   : no bit set
module lsb_priority_enc import bit_scan_pkg::*; #(parameter int WIDTH = 8) (
   input  logic [WIDTH-1:0]        vec,
   output logic [clog2(WIDTH)-1:0] idx,
   output logic                    single,
   output logic                    zero
);
   localparam int IDXW = clog2(WIDTH);
   // Scan from the top so the lowest set bit is the last to win.
   always_comb begin
      idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) if (vec[i]) idx = IDXW'(i);
   end
   assign zero   = ~|vec;
   assign single = !zero && ((vec & ~WIDTH'(onehot(int'(idx), WIDTH))) == '0);
endmodule

// File: rtl/bit_scan_iterator.sv
// bit_scan_iterator: emits the index of every set bit of an accepted vector, lowest first.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bit_scan_iterator_if (vector in, index beats out, flush)
module bit_scan_iterator import bit_scan_pkg::*; #(parameter int WIDTH = 8) (
   input logic                clk,
   input logic                rst_n,
   bit_scan_iterator_if.slave bus
);
   localparam int IDXW = clog2(WIDTH);
   state_t           r_state;
   logic [WIDTH-1:0] r_rem;
   logic             r_zero;
   logic [IDXW-1:0]  w_idx;
   logic             w_single;
   logic             w_empty;
   logic             w_scan;
   lsb_priority_enc #(.WIDTH(WIDTH)) u_enc (
      .vec    (r_rem),
      .idx    (w_idx),
      .single (w_single),
      .zero   (w_empty)
   );
   assign w_scan        = r_state == SCAN;
   assign bus.in_ready  = !w_scan && !bus.flush;
   assign bus.out_valid = w_scan;
   assign bus.out_idx   = w_idx;
   // rem is empty during SCAN only for an all-zero vector, whose sole beat is also last.
   assign bus.out_last  = w_scan && (w_single || w_empty);
   assign bus.out_none  = w_scan && r_zero;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_rem   <= '0;
         r_zero  <= 1'b0;
      end else if (bus.flush) begin
         r_state <= IDLE;
         r_rem   <= '0;
         r_zero  <= 1'b0;
      end else if (!w_scan) begin
         if (bus.in_valid) begin
            r_state <= SCAN;
            r_rem   <= bus.in_data;
            r_zero  <= ~|bus.in_data;
         end
      end else if (bus.out_ready) begin
         r_rem <= r_rem & ~WIDTH'(onehot(int'(w_idx), WIDTH));
         if (bus.out_last) begin
            r_state <= IDLE;
            r_zero  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_bit_scan_iterator.sv
// tb_bit_scan_iterator: table, directed and randomized checks of bit_scan_iterator.
module tb_bit_scan_iterator;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_fail = 0;
   always #5 clk = ~clk;
   bit_scan_iterator_if #(.WIDTH(8)) b8();
   bit_scan_iterator_if #(.WIDTH(16)) b16();
   bit_scan_iterator #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
   bit_scan_iterator #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
   typedef struct {
      logic [7:0] vec;
      int         beats;
      int         first;
      int         lastidx;
      int         none;
   } vec_t;
   vec_t tbl[6];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic send8(input logic [7:0] v);
      int t = 0;
      while (!b8.in_ready && t < 40) begin step(); t++; end
      chk("send_ready", 32'(b8.in_ready), 1);
      b8.in_valid = 1'b1;
      b8.in_data  = v;
      step();
      b8.in_valid = 1'b0;
      b8.in_data  = $urandom;
      chk("accept_latency", 32'(b8.out_valid), 1);
   endtask
   initial begin
      int q[$];
      int got[$];
      int gl, gn, t;
      bit none_exp, done;
      tbl[0] = '{8'b1010_0100, 3, 2, 7, 0};
      tbl[1] = '{8'h00, 1, 0, 0, 1};
      tbl[2] = '{8'h80, 1, 7, 7, 0};
      tbl[3] = '{8'h01, 1, 0, 0, 0};
      tbl[4] = '{8'hFF, 8, 0, 7, 0};
      tbl[5] = '{8'h18, 2, 3, 4, 0};
      {b8.in_valid, b8.flush, b8.out_ready} = '0;
      {b16.in_valid, b16.flush, b16.out_ready} = '0;
      b8.in_data = '0;
      b16.in_data = '0;
      step();
      chk("rst_out_valid", 32'(b8.out_valid), 0);
      chk("rst_in_ready", 32'(b8.in_ready), 1);
      chk("rst_idx", 32'(b8.out_idx), 0);
      chk("rst_last", 32'(b8.out_last), 0);
      chk("rst_none", 32'(b8.out_none), 0);
      rst_n = 1'b1;
      step();
      // asynchronous reset mid-scan
      b8.out_ready = 1'b1;
      send8(8'hFF);
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(b8.out_valid), 0);
      chk("async_rst_ready", 32'(b8.in_ready), 1);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_valid", 32'(b8.out_valid), 0);
      send8(8'h02);
      chk("post_rst_idx", 32'(b8.out_idx), 1);
      chk("post_rst_last", 32'(b8.out_last), 1);
      step();
      chk("post_rst_idle", 32'(b8.in_ready), 1);
      // table-driven vectors, always ready
      foreach (tbl[k]) begin
         send8(tbl[k].vec);
         got.delete();
         gl = 0;
         gn = 0;
         t = 0;
         done = 0;
         while (!done && t < 20) begin
            if (b8.out_valid) begin
               got.push_back(int'(b8.out_idx));
               gn = int'(b8.out_none);
               if (b8.out_last) begin gl = got.size(); done = 1; end
            end
            step();
            t++;
         end
         chk($sformatf("tbl%0d_beats", k), got.size(), tbl[k].beats);
         chk($sformatf("tbl%0d_lastpos", k), gl, tbl[k].beats);
         chk($sformatf("tbl%0d_first", k), got.size() > 0 ? got[0] : -1, tbl[k].first);
         chk($sformatf("tbl%0d_lastidx", k), got.size() > 0 ? got[got.size()-1] : -1, tbl[k].lastidx);
         chk($sformatf("tbl%0d_none", k), gn, tbl[k].none);
         chk($sformatf("tbl%0d_idle_after", k), 32'(b8.in_ready), 1);
      end
      // backpressure
      b8.out_ready = 1'b0;
      send8(8'h81);
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 32'(b8.out_valid), 1);
         chk("bp_idx", 32'(b8.out_idx), 0);
         chk("bp_last", 32'(b8.out_last), 0);
         step();
      end
      b8.out_ready = 1'b1;
      chk("bp_rel_idx0", 32'(b8.out_idx), 0);
      step();
      chk("bp_rel_idx7", 32'(b8.out_idx), 7);
      chk("bp_rel_last", 32'(b8.out_last), 1);
      step();
      chk("bp_idle", 32'(b8.in_ready), 1);
      // flush mid-scan beats the simultaneous transfer
      send8(8'hFF);
      chk("fl_idx0", 32'(b8.out_idx), 0);
      step();
      chk("fl_idx1", 32'(b8.out_idx), 1);
      step();
      chk("fl_idx2_shown", 32'(b8.out_idx), 2);
      b8.flush = 1'b1;
      #1 chk("fl_ready_forced", 32'(b8.in_ready), 0);
      step();
      b8.flush = 1'b0;
      #1;
      chk("fl_valid", 32'(b8.out_valid), 0);
      chk("fl_ready", 32'(b8.in_ready), 1);
      chk("fl_none", 32'(b8.out_none), 0);
      // flush in IDLE blocks acceptance
      b8.flush = 1'b1;
      b8.in_valid = 1'b1;
      b8.in_data = 8'h05;
      #1 chk("fl_idle_ready", 32'(b8.in_ready), 0);
      step();
      {b8.flush, b8.in_valid} = 2'b00;
      chk("fl_idle_noaccept", 32'(b8.out_valid), 0);
      // 16-bit instance; in_valid held over the final beat
      b16.out_ready = 1'b1;
      b16.in_valid = 1'b1;
      b16.in_data = 16'h8001;
      step();
      b16.in_valid = 1'b0;
      chk("w16_idx0", 32'(b16.out_idx), 0);
      chk("w16_last0", 32'(b16.out_last), 0);
      step();
      chk("w16_idx15", 32'(b16.out_idx), 15);
      chk("w16_last15", 32'(b16.out_last), 1);
      b16.in_valid = 1'b1;
      b16.in_data = 16'h0003;
      #1 chk("w16_no_reload_ready", 32'(b16.in_ready), 0);
      step();
      chk("w16_idle_valid", 32'(b16.out_valid), 0);
      chk("w16_idle_ready", 32'(b16.in_ready), 1);
      step();
      b16.in_valid = 1'b0;
      chk("w16_reload_valid", 32'(b16.out_valid), 1);
      chk("w16_reload_idx0", 32'(b16.out_idx), 0);
      step();
      chk("w16_reload_idx1", 32'(b16.out_idx), 1);
      chk("w16_reload_last", 32'(b16.out_last), 1);
      step();
      // randomized vectors against a list-of-indices model
      for (int v = 0; v < 150; v++) begin
         logic [7:0] rv;
         rv = (v % 10 == 0) ? 8'h00 : 8'($urandom);
         q.delete();
         for (int i = 0; i < 8; i++) if (rv[i]) q.push_back(i);
         none_exp = q.size() == 0;
         if (none_exp) q.push_back(0);
         send8(rv);
         done = 0;
         t = 0;
         while (!done && t < 80) begin
            chk("rnd_valid", 32'(b8.out_valid), 1);
            chk("rnd_idx", 32'(b8.out_idx), q[0]);
            chk("rnd_last", 32'(b8.out_last), 32'(q.size() == 1));
            chk("rnd_none", 32'(b8.out_none), 32'(none_exp));
            b8.out_ready = $urandom_range(0, 3) != 0;
            b8.flush = $urandom_range(0, 40) == 0;
            if (b8.flush) begin
               step();
               b8.flush = 1'b0;
               chk("rnd_flush_idle", 32'(b8.out_valid), 0);
               done = 1;
            end else if (b8.out_ready) begin
               void'(q.pop_front());
               step();
               if (q.size() == 0) begin
                  chk("rnd_end_idle", 32'(b8.in_ready), 1);
                  done = 1;
               end
            end else step();
            t++;
         end
         if (!done) chk("rnd_timeout", 0, 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
